// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler
// Sequences piece-motion commands (shift, rotate, gravity drop) into the grid engine over a
// single valid/ready channel. Player buttons are edge-detected; left/right auto-repeat through
// a DAS FSM per direction. A gravity timer, whose period shortens with level, raises DROP.
// Simultaneous requests are held in pending flags and issued one per cycle by fixed priority.
//
// Optional feature macro: TETRIS_HARD_DROP_EN adds btn_hard and the HARD_DROP (cmd=5) command.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   enable                 grid is falling; scheduling allowed
//   game_over              grid reports game over; output squashed
//   btn_left/right/rotate  synchronized button levels
//   btn_down               soft-drop level (shortens gravity period)
//   btn_hard               hard-drop level (TETRIS_HARD_DROP_EN only)
//   row_cleared            one-cycle pulse per cleared row
//   cmd_ready/cmd_valid    command handshake
//   cmd                    0 NONE, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 DROP, 5 HARD_DROP
//   level, lines           current level (0..15) and saturating cleared-line count
module tetris_move_scheduler #(
    parameter int unsigned GRAVITY_BASE     = 40_000_000,
    parameter int unsigned GRAVITY_STEP     = 3_000_000,
    parameter int unsigned GRAVITY_MIN      = 4_000_000,
    parameter int unsigned SOFT_DROP_PERIOD = 8_000_000,
    parameter int unsigned DAS_DELAY        = 8_000_000,
    parameter int unsigned DAS_REPEAT       = 2_000_000,
    parameter int unsigned LINES_PER_LEVEL  = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       game_over,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       btn_down,
    input  logic       row_cleared,
    input  logic       cmd_ready,
`ifdef TETRIS_HARD_DROP_EN
    input  logic       btn_hard,
`endif
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic [3:0] level,
    output logic [7:0] lines
);

    localparam int unsigned CW = 26;

    typedef enum logic [2:0] {
        CmdNone   = 3'd0,
        CmdLeft   = 3'd1,
        CmdRight  = 3'd2,
        CmdRotate = 3'd3,
        CmdDrop   = 3'd4,
        CmdHard   = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        DasIdle,
        DasDelay,
        DasRepeat
    } das_e;

    // Scheduling is live only while falling and not over.
    logic active;
    assign active = enable & ~game_over;

    // ---------------------------------------------------------------- output / pending state
    logic    cmd_valid_q, cmd_valid_d;
    cmd_e    cmd_q, cmd_d;
    logic    pend_left_q, pend_left_d;
    logic    pend_right_q, pend_right_d;
    logic    pend_rot_q, pend_rot_d;
    logic    pend_drop_q, pend_drop_d;
    logic    pend_hard_q, pend_hard_d;
    logic    rot_prev_q;
    logic    hard_prev_q;
    logic    hard_level;

`ifdef TETRIS_HARD_DROP_EN
    assign hard_level = btn_hard;
`else
    assign hard_level = 1'b0;
`endif

    // ---------------------------------------------------------------- DAS state (0 left, 1 right)
    das_e            das_q     [2];
    das_e            das_d     [2];
    logic [CW-1:0]   das_cnt_q [2];
    logic [CW-1:0]   das_cnt_d [2];
    logic [1:0]      shift_evt;
    logic [1:0]      das_btn;
    logic            shift_ok;

    assign das_btn  = {btn_right, btn_left};
    // Opposing shifts cancel each other entirely.
    assign shift_ok = active & ~(btn_left & btn_right);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            das_d[i]     = das_q[i];
            das_cnt_d[i] = das_cnt_q[i];
            shift_evt[i] = 1'b0;
            if (!shift_ok || !das_btn[i]) begin
                das_d[i]     = DasIdle;
                das_cnt_d[i] = '0;
            end else begin
                unique case (das_q[i])
                    DasIdle: begin
                        shift_evt[i] = 1'b1;
                        das_d[i]     = DasDelay;
                        das_cnt_d[i] = '0;
                    end
                    DasDelay: begin
                        if (das_cnt_q[i] == CW'(DAS_DELAY - 1)) begin
                            shift_evt[i] = 1'b1;
                            das_d[i]     = DasRepeat;
                            das_cnt_d[i] = '0;
                        end else begin
                            das_cnt_d[i] = das_cnt_q[i] + 1'b1;
                        end
                    end
                    DasRepeat: begin
                        if (das_cnt_q[i] == CW'(DAS_REPEAT - 1)) begin
                            shift_evt[i] = 1'b1;
                            das_cnt_d[i] = '0;
                        end else begin
                            das_cnt_d[i] = das_cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        das_d[i]     = DasIdle;
                        das_cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- edge events
    logic rot_evt;
    logic hard_evt;
    assign rot_evt  = active & btn_rotate & ~rot_prev_q;
    assign hard_evt = active & hard_level & ~hard_prev_q;

    // ---------------------------------------------------------------- level / lines
    logic [3:0] level_q;
    logic [7:0] lines_q;
    logic [7:0] sub_q;

    // ---------------------------------------------------------------- gravity period
    logic [CW-1:0] reduction;
    logic [CW-1:0] period_normal;
    logic [CW-1:0] period;

    always_comb begin
        reduction = CW'(level_q) * CW'(GRAVITY_STEP);
        // Guard the subtraction so a large level cannot wrap below the floor.
        if (reduction >= CW'(GRAVITY_BASE) ||
            (CW'(GRAVITY_BASE) - reduction) < CW'(GRAVITY_MIN)) begin
            period_normal = CW'(GRAVITY_MIN);
        end else begin
            period_normal = CW'(GRAVITY_BASE) - reduction;
        end
        if (btn_down && CW'(SOFT_DROP_PERIOD) < period_normal) begin
            period = CW'(SOFT_DROP_PERIOD);
        end else begin
            period = period_normal;
        end
    end

    // ---------------------------------------------------------------- arbitration
    cmd_e grant_cmd;
    logic can_grant;

    assign can_grant = active & (~cmd_valid_q | cmd_ready);

    always_comb begin
        grant_cmd = CmdNone;
        if (can_grant) begin
            if (pend_hard_q) begin
                grant_cmd = CmdHard;
            end else if (pend_drop_q) begin
                grant_cmd = CmdDrop;
            end else if (pend_rot_q) begin
                grant_cmd = CmdRotate;
            end else if (pend_left_q) begin
                grant_cmd = CmdLeft;
            end else if (pend_right_q) begin
                grant_cmd = CmdRight;
            end
        end
    end

    // ---------------------------------------------------------------- gravity counter
    logic [CW-1:0] grav_q, grav_d;
    logic          drop_evt;

    always_comb begin
        grav_d   = grav_q;
        drop_evt = 1'b0;
        // A granted hard drop restarts the fall timer from zero.
        if (!active || grant_cmd == CmdHard) begin
            grav_d = '0;
        end else if (grav_q >= period - 1'b1) begin
            // ">=" also catches a period that shrank below the running count.
            drop_evt = 1'b1;
            grav_d   = '0;
        end else begin
            grav_d = grav_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------- pending flags and output
    always_comb begin
        pend_left_d  = 1'b0;
        pend_right_d = 1'b0;
        pend_rot_d   = 1'b0;
        pend_drop_d  = 1'b0;
        pend_hard_d  = 1'b0;
        if (active) begin
            pend_left_d  = (pend_left_q  & (grant_cmd != CmdLeft))   | shift_evt[0];
            pend_right_d = (pend_right_q & (grant_cmd != CmdRight))  | shift_evt[1];
            pend_rot_d   = (pend_rot_q   & (grant_cmd != CmdRotate)) | rot_evt;
            pend_drop_d  = (pend_drop_q  & (grant_cmd != CmdDrop))   | drop_evt;
            pend_hard_d  = (pend_hard_q  & (grant_cmd != CmdHard))   | hard_evt;
            // A hard drop supersedes any queued gravity step.
            if (grant_cmd == CmdHard) begin
                pend_drop_d = 1'b0;
            end
        end

        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        if (game_over) begin
            cmd_valid_d = 1'b0;
            cmd_d       = CmdNone;
        end else if (grant_cmd != CmdNone) begin
            cmd_valid_d = 1'b1;
            cmd_d       = grant_cmd;
        end else if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
            cmd_d       = CmdNone;
        end
    end

    // ---------------------------------------------------------------- state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid_q  <= 1'b0;
            cmd_q        <= CmdNone;
            pend_left_q  <= 1'b0;
            pend_right_q <= 1'b0;
            pend_rot_q   <= 1'b0;
            pend_drop_q  <= 1'b0;
            pend_hard_q  <= 1'b0;
            rot_prev_q   <= 1'b0;
            hard_prev_q  <= 1'b0;
            grav_q       <= '0;
            for (int i = 0; i < 2; i++) begin
                das_q[i]     <= DasIdle;
                das_cnt_q[i] <= '0;
            end
        end else begin
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            pend_left_q  <= pend_left_d;
            pend_right_q <= pend_right_d;
            pend_rot_q   <= pend_rot_d;
            pend_drop_q  <= pend_drop_d;
            pend_hard_q  <= pend_hard_d;
            rot_prev_q   <= btn_rotate;
            hard_prev_q  <= hard_level;
            grav_q       <= grav_d;
            for (int i = 0; i < 2; i++) begin
                das_q[i]     <= das_d[i];
                das_cnt_q[i] <= das_cnt_d[i];
            end
        end
    end

    // Line and level accounting runs regardless of enable/game_over.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lines_q <= '0;
            level_q <= '0;
            sub_q   <= '0;
        end else if (row_cleared) begin
            if (lines_q != 8'hFF) begin
                lines_q <= lines_q + 1'b1;
            end
            if (sub_q == 8'(LINES_PER_LEVEL - 1)) begin
                sub_q <= '0;
                if (level_q != 4'hF) begin
                    level_q <= level_q + 1'b1;
                end
            end else begin
                sub_q <= sub_q + 1'b1;
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign level     = level_q;
    assign lines     = lines_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Bench for tetris_move_scheduler: directed scenarios followed by a randomized phase, all
// compared every cycle against a time-stamp based reference model of the scheduling rules.
module tb_tetris_move_scheduler;

    localparam int BASE = 100;
    localparam int STEP = 10;
    localparam int GMIN = 20;
    localparam int SOFT = 10;
    localparam int DD   = 16;
    localparam int DR   = 4;
    localparam int LPL  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       game_over = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rotate = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_hard = 1'b0;
    logic       row_cleared = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic [3:0] level;
    logic [7:0] lines;

    always #5 clk = ~clk;

    tetris_move_scheduler #(
        .GRAVITY_BASE    (BASE),
        .GRAVITY_STEP    (STEP),
        .GRAVITY_MIN     (GMIN),
        .SOFT_DROP_PERIOD(SOFT),
        .DAS_DELAY       (DD),
        .DAS_REPEAT      (DR),
        .LINES_PER_LEVEL (LPL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .game_over  (game_over),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_rotate (btn_rotate),
        .btn_down   (btn_down),
        .row_cleared(row_cleared),
        .cmd_ready  (cmd_ready),
`ifdef TETRIS_HARD_DROP_EN
        .btn_hard   (btn_hard),
`endif
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .level      (level),
        .lines      (lines)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state: pending requests as a set, timing as timestamps.
    bit m_valid;
    int m_cmd;
    bit p_left, p_right, p_rot, p_drop, p_hard;
    bit rot_prev, hard_prev;
    int left_start, right_start;
    int grav_origin;
    int n_pulses;

    int n_xfer[8] = '{default: 0};
    int drop_times[$];
    int hard_time = 0;
    int d0, d1, d2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit das_fire(input int e);
        return (e == 0) || (e == DD) || (e > DD && ((e - DD) % DR) == 0);
    endfunction

    function automatic int exp_level(input int n);
        return (n / LPL > 15) ? 15 : n / LPL;
    endfunction

    function automatic int exp_lines(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_cmd = 0;
        p_left = 0; p_right = 0; p_rot = 0; p_drop = 0; p_hard = 0;
        rot_prev = 0; hard_prev = 0;
        left_start = -1; right_start = -1;
        grav_origin = cyc + 1;
        n_pulses = 0;
    endtask

    // One clock edge of the scheduling rules, using the inputs present at that edge.
    task automatic model_edge();
        bit act, ok, e_l, e_r, e_rot, e_drop, e_hard;
        int per, gr;
        act = enable && !game_over;
        ok  = act && !(btn_left && btn_right);
        per = BASE - exp_level(n_pulses) * STEP;
        if (per < GMIN) per = GMIN;
        if (btn_down && SOFT < per) per = SOFT;
        gr = 0;
        if (act && (!m_valid || cmd_ready)) begin
            if (p_hard) gr = 5;
            else if (p_drop) gr = 4;
            else if (p_rot) gr = 3;
            else if (p_left) gr = 1;
            else if (p_right) gr = 2;
        end
        e_rot  = act && btn_rotate && !rot_prev;
        e_hard = act && btn_hard && !hard_prev;
        e_l = 0; e_r = 0;
        if (ok && btn_left) begin
            if (left_start < 0) left_start = cyc;
            e_l = das_fire(cyc - left_start);
        end else left_start = -1;
        if (ok && btn_right) begin
            if (right_start < 0) right_start = cyc;
            e_r = das_fire(cyc - right_start);
        end else right_start = -1;
        e_drop = 0;
        if (!act || gr == 5) grav_origin = cyc + 1;
        else if (cyc - grav_origin >= per - 1) begin
            e_drop = 1;
            grav_origin = cyc + 1;
        end
        if (!act) begin
            p_left = 0; p_right = 0; p_rot = 0; p_drop = 0; p_hard = 0;
        end else begin
            p_left  = (p_left && gr != 1) || e_l;
            p_right = (p_right && gr != 2) || e_r;
            p_rot   = (p_rot && gr != 3) || e_rot;
            p_drop  = ((p_drop && gr != 4) || e_drop) && gr != 5;
            p_hard  = (p_hard && gr != 5) || e_hard;
        end
        if (game_over) begin
            m_valid = 0; m_cmd = 0;
        end else if (gr != 0) begin
            m_valid = 1; m_cmd = gr;
        end else if (m_valid && cmd_ready) begin
            m_valid = 0; m_cmd = 0;
        end
        rot_prev  = btn_rotate;
        hard_prev = btn_hard;
        if (row_cleared) n_pulses++;
    endtask

    task automatic tick();
        bit xf;
        logic [2:0] xc;
        xf = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
        xc = cmd;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (xf) begin
            n_xfer[xc]++;
            if (xc == 3'd4) drop_times.push_back(cyc);
            if (xc == 3'd5) hard_time = cyc;
        end
        check("cmd_valid", cmd_valid, m_valid);
        if (m_valid) check("cmd", cmd, m_cmd);
        check("level", level, exp_level(n_pulses));
        check("lines", lines, exp_lines(n_pulses));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic restart_gravity();
        enable = 0;
        tick();
        enable = 1;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 0);
        check("rst_level", level, 0);
        check("rst_lines", lines, 0);
        #10;
        model_reset();
        reset_n = 1; enable = 1; cmd_ready = 1;

        // Gravity at level 0: DROP every 100 cycles
        d0 = n_xfer[4];
        ticks(320);
        check("grav_count", n_xfer[4] - d0, 3);
        check("grav_interval", drop_times[$] - drop_times[$-1], 100);

        // Soft drop: every 10 cycles
        btn_down = 1;
        ticks(60);
        check("soft_interval", drop_times[$] - drop_times[$-1], 10);
        btn_down = 0;

        // DAS: 40 cycles held -> 7 LEFT, none after release
        restart_gravity();
        d0 = n_xfer[1];
        btn_left = 1;
        ticks(40);
        btn_left = 0;
        check("das_count", n_xfer[1] - d0, 7);
        ticks(20);
        check("das_release", n_xfer[1] - d0, 7);

        // Backpressure: gravity and rotate edge on the same edge
        restart_gravity();
        cmd_ready = 0;
        ticks(99);
        btn_rotate = 1;
        tick();
        tick();
        d0 = n_xfer[4]; d1 = n_xfer[3];
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", cmd_valid, 1);
            check("bp_cmd", cmd, 4);
            tick();
        end
        cmd_ready = 1;
        btn_rotate = 0;
        ticks(3);
        check("bp_drop", n_xfer[4] - d0, 1);
        check("bp_rot", n_xfer[3] - d1, 1);

`ifdef TETRIS_HARD_DROP_EN
        // Hard drop over a pending DROP: one HARD, DROP discarded, gravity restarted
        cmd_ready = 0;
        restart_gravity();
        btn_rotate = 1;
        tick();
        btn_rotate = 0;
        ticks(99);
        btn_hard = 1;
        tick();
        d0 = n_xfer[4]; d2 = n_xfer[5];
        cmd_ready = 1;
        ticks(111);
        btn_hard = 0;
        check("hard_count", n_xfer[5] - d2, 1);
        check("hard_drop_count", n_xfer[4] - d0, 1);
        check("hard_next_drop", drop_times[$] - hard_time, 101);
`endif

        // Level: 6 rows -> level 3, period 70; 40 more -> level 15, period 20
        cmd_ready = 1;
        for (int i = 0; i < 6; i++) begin
            row_cleared = 1; tick();
            row_cleared = 0; tick();
        end
        check("lvl_lines6", lines, 6);
        check("lvl_level3", level, 3);
        ticks(250);
        check("lvl_period70", drop_times[$] - drop_times[$-1], 70);
        for (int i = 0; i < 40; i++) begin
            row_cleared = 1; tick();
            row_cleared = 0; tick();
        end
        check("lvl_lines46", lines, 46);
        check("lvl_level15", level, 15);
        ticks(80);
        check("lvl_period20", drop_times[$] - drop_times[$-1], 20);

        // Both shifts held: nothing issued
        d0 = n_xfer[1]; d1 = n_xfer[2];
        btn_left = 1; btn_right = 1;
        ticks(30);
        btn_left = 0; btn_right = 0;
        check("both_left", n_xfer[1] - d0, 0);
        check("both_right", n_xfer[2] - d1, 0);

        // Game over squashes an in-flight command
        cmd_ready = 0;
        for (int i = 0; i < 40 && cmd_valid !== 1'b1; i++) tick();
        check("go_valid_seen", cmd_valid, 1);
        game_over = 1;
        tick();
        check("go_valid", cmd_valid, 0);
        check("go_cmd", cmd, 0);
        d0 = n_xfer[1] + n_xfer[2] + n_xfer[3] + n_xfer[4] + n_xfer[5];
        cmd_ready = 1;
        ticks(30);
        check("go_quiet", n_xfer[1] + n_xfer[2] + n_xfer[3] + n_xfer[4] + n_xfer[5] - d0, 0);
        game_over = 0;

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) btn_left = ~btn_left;
            if ($urandom_range(0, 19) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 7) == 0) btn_rotate = ~btn_rotate;
            if ($urandom_range(0, 29) == 0) btn_down = ~btn_down;
`ifdef TETRIS_HARD_DROP_EN
            if ($urandom_range(0, 24) == 0) btn_hard = ~btn_hard;
`endif
            cmd_ready   = ($urandom_range(0, 3) != 0);
            row_cleared = ($urandom_range(0, 19) == 0);
            enable      = ($urandom_range(0, 99) != 0);
            game_over   = ($urandom_range(0, 299) == 0);
            tick();
        end

        // Asynchronous reset while a command is waiting
        btn_left = 0; btn_right = 0; btn_rotate = 0; btn_down = 0; btn_hard = 0;
        row_cleared = 0; enable = 1; game_over = 0; cmd_ready = 0;
        for (int i = 0; i < 40 && cmd_valid !== 1'b1; i++) tick();
        check("arst_pre_valid", cmd_valid, 1);
        #2;
        reset_n = 0;
        #1;
        check("arst_valid", cmd_valid, 0);
        check("arst_cmd", cmd, 0);
        check("arst_level", level, 0);
        check("arst_lines", lines, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
